sp_ram_arb2: RTL

- Two-requester arbiter that time-shares one single-port RAM (one port, read or write per cycle, 1-cycle registered read).
- Each requester issues read/write commands over a valid/ready handshake; read data returns on a per-requester response strobe.
- Default policy is round-robin, so neither requester starves.
- Sits directly in front of the team's single-port RAM wrapper and drives its ena/wea/addra/dina; takes its douta.

---
 rtl/sp_ram_arb2.sv | 104 ++++++++++
 1 files changed

// File: rtl/sp_ram_arb2.sv
// Two-requester arbiter time-sharing one single-port RAM with a 1-cycle registered read.
// Define SP_RAM_ARB_STRICT_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module sp_ram_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta
);

  logic                  acc_p0;
  logic                  gnt_sel_p0;
  logic                  acc_we_p0;
  logic [ADDR_WIDTH-1:0] acc_addr_p0;
  logic [DATA_WIDTH-1:0] acc_wdata_p0;
  logic [1:0]            rd_pend_p1;

  // Stage p0: combinational grant; nothing is accepted while reset is asserted.
  assign acc_p0 = (req0_valid | req1_valid) & ~rsta;

`ifdef SP_RAM_ARB_STRICT_PRIO_EN
  assign gnt_sel_p0 = ~req0_valid;
`else
  logic last_gnt;

  always_comb begin
    gnt_sel_p0 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_sel_p0 = ~last_gnt;
    end else if (req1_valid) begin
      gnt_sel_p0 = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      last_gnt <= 1'b1;
    end else if (acc_p0) begin
      last_gnt <= gnt_sel_p0;
    end
  end
`endif

  assign req0_ready = acc_p0 & ~gnt_sel_p0;
  assign req1_ready = acc_p0 & gnt_sel_p0;

  always_comb begin
    acc_we_p0    = 1'b0;
    acc_addr_p0  = '0;
    acc_wdata_p0 = '0;
    if (acc_p0) begin
      if (gnt_sel_p0) begin
        acc_we_p0    = req1_we;
        acc_addr_p0  = req1_addr;
        acc_wdata_p0 = req1_wdata;
      end else begin
        acc_we_p0    = req0_we;
        acc_addr_p0  = req0_addr;
        acc_wdata_p0 = req0_wdata;
      end
    end
  end

  assign ram_ena   = acc_p0;
  assign ram_wea   = acc_we_p0;
  assign ram_addra = acc_addr_p0;
  assign ram_dina  = acc_wdata_p0;

  // Stage p1: read tag follows the RAM's registered output by one cycle.
  always_ff @(posedge clka) begin
    if (rsta) begin
      rd_pend_p1 <= 2'b00;
    end else begin
      rd_pend_p1[0] <= acc_p0 & ~gnt_sel_p0 & ~acc_we_p0;
      rd_pend_p1[1] <= acc_p0 & gnt_sel_p0 & ~acc_we_p0;
    end
  end

  // Reset in the response cycle suppresses the strobe.
  assign rsp0_valid = rd_pend_p1[0] & ~rsta;
  assign rsp1_valid = rd_pend_p1[1] & ~rsta;
  assign rsp0_rdata = ram_douta;
  assign rsp1_rdata = ram_douta;

endmodule
